// File: rtl/wiphy_cordic_pkg.sv
`default_nettype none
// ============================================================================
// Package     : wiphy_cordic_pkg
// Description : Constants and elaboration-time helpers shared by the CORDIC
//               converters (polar_to_cartesian, cartesian_to_polar).
// Revision    : 1.0 - initial release
// ============================================================================
package wiphy_cordic_pkg;

    // Asymptotic CORDIC magnitude growth, prod(sqrt(1 + 2^-2n)).
    localparam real CORDIC_GAIN = 1.6467602;

    // atan(2^-n) in phase units where 2^(width-1) == pi, truncated toward zero.
    // pi is taken as 4*atan(1) so that entry 0 is exactly 2^(width-3).
    function automatic int atan_lut_entry(input int n, input int width);
        return $rtoi($atan(1.0 / (2.0 ** n)) * (2.0 ** (width - 1)) / (4.0 * $atan(1.0)));
    endfunction

    // Gain-compensation multiplier, 1/CORDIC_GAIN scaled by 2^(width-1), rounded.
    function automatic int inv_gain(input int width);
        return $rtoi((2.0 ** (width - 1)) / CORDIC_GAIN + 0.5);
    endfunction

    // pi/2 in phase units.
    function automatic longint pi_2(input int width);
        return longint'(64'(1) << (width - 2));
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_rotate_stage.sv
`default_nettype none
// ============================================================================
// Module      : cordic_rotate_stage
// Description : One registered CORDIC micro-rotation in rotation mode. The
//               rotation direction follows the sign of the residual phase.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_rotate_stage
    import wiphy_cordic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHIFT = 0,
    parameter int ATAN  = 0
) (
    input  logic                      clk,
    input  logic                      i_en,
    input  logic signed [WIDTH+1:0]   i_x,
    input  logic signed [WIDTH+1:0]   i_y,
    input  logic signed [WIDTH-1:0]   i_z,
    output logic signed [WIDTH+1:0]   o_x,
    output logic signed [WIDTH+1:0]   o_y,
    output logic signed [WIDTH-1:0]   o_z
);

    localparam logic signed [WIDTH-1:0] c_atan = WIDTH'(ATAN);

    // Non-negative residual phase rotates counter-clockwise (d = +1).
    logic w_dir_pos;
    assign w_dir_pos = ~i_z[WIDTH-1];

    // Micro-rotation register; holds while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (w_dir_pos) begin
                o_x <= i_x - (i_y >>> SHIFT);
                o_y <= i_y + (i_x >>> SHIFT);
                o_z <= i_z - c_atan;
            end else begin
                o_x <= i_x + (i_y >>> SHIFT);
                o_y <= i_y - (i_x >>> SHIFT);
                o_z <= i_z + c_atan;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/polar_to_cartesian.sv
`default_nettype none
// ============================================================================
// Module      : polar_to_cartesian
// Description : Pipelined rotation-mode CORDIC, {magnitude, phase} stream in,
//               {Q, I} stream out. Quadrant pre-rotation, DEPTH registered
//               micro-rotations, then gain compensation with saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module polar_to_cartesian
    import wiphy_cordic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [2*WIDTH-1:0]   s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [2*WIDTH-1:0]   m_data
);

    localparam int c_xw = WIDTH + 2;
    localparam int c_pw = 2 * WIDTH + 4;

    localparam logic signed [WIDTH-1:0] c_pi_2     = WIDTH'(pi_2(WIDTH));
    localparam logic signed [c_pw-1:0]  c_inv_gain = c_pw'(inv_gain(WIDTH));
    localparam logic signed [c_pw-1:0]  c_round    = c_pw'(1) <<< (WIDTH - 2);
    localparam logic signed [c_pw-1:0]  c_sat_max  = (c_pw'(1) <<< (WIDTH - 1)) - 1;
    localparam logic signed [c_pw-1:0]  c_sat_min  = -(c_pw'(1) <<< (WIDTH - 1));

    // Multiply by 1/gain with round-half-up, then clamp into the output range.
    function automatic logic signed [WIDTH-1:0] scale_sat(input logic signed [c_xw-1:0] v);
        logic signed [c_pw-1:0] t;
        t = (c_pw'(v) * c_inv_gain + c_round) >>> (WIDTH - 1);
        if (t > c_sat_max)      return c_sat_max[WIDTH-1:0];
        else if (t < c_sat_min) return c_sat_min[WIDTH-1:0];
        else                    return t[WIDTH-1:0];
    endfunction

    logic                     w_adv;
    logic [DEPTH+1:0]         r_valid;
    logic signed [WIDTH-1:0]  w_mag;
    logic signed [WIDTH-1:0]  w_phase;
    logic signed [c_xw-1:0]   w_mag_wide;
    logic signed [c_xw-1:0]   w_x_pre;
    logic signed [c_xw-1:0]   w_y_pre;
    logic signed [WIDTH-1:0]  w_z_pre;
    logic signed [c_xw-1:0]   r_x0;
    logic signed [c_xw-1:0]   r_y0;
    logic signed [WIDTH-1:0]  r_z0;
    logic signed [c_xw-1:0]   w_x [0:DEPTH];
    logic signed [c_xw-1:0]   w_y [0:DEPTH];
    logic signed [WIDTH-1:0]  w_z [0:DEPTH];
    logic signed [WIDTH-1:0]  r_i;
    logic signed [WIDTH-1:0]  r_q;

    // Whole pipeline moves together whenever the output slot is free or drained.
    assign w_adv   = !r_valid[DEPTH+1] || m_ready;
    assign s_ready = w_adv;
    assign m_valid = r_valid[DEPTH+1];
    assign m_data  = {r_q, r_i};

    assign w_mag      = s_data[2*WIDTH-1:WIDTH];
    assign w_phase    = s_data[WIDTH-1:0];
    assign w_mag_wide = c_xw'(w_mag);

    // Quadrant pre-rotation brings the residual phase into [-pi/2, pi/2].
    always_comb begin
        w_x_pre = w_mag_wide;
        w_y_pre = '0;
        w_z_pre = w_phase;
        case (w_phase[WIDTH-1 -: 2])
            2'b01: begin
                w_x_pre = '0;
                w_y_pre = w_mag_wide;
                w_z_pre = w_phase - c_pi_2;
            end
            2'b10: begin
                w_x_pre = '0;
                w_y_pre = -w_mag_wide;
                w_z_pre = w_phase + c_pi_2;
            end
            default: begin
            end
        endcase
    end

    // Pre-rotation register (stage 0 of the datapath, not reset).
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_x0 <= w_x_pre;
            r_y0 <= w_y_pre;
            r_z0 <= w_z_pre;
        end
    end

    // Valid shift register; reset discards every in-flight beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (w_adv) begin
            r_valid <= {r_valid[DEPTH:0], s_valid};
        end
    end

    assign w_x[0] = r_x0;
    assign w_y[0] = r_y0;
    assign w_z[0] = r_z0;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        cordic_rotate_stage #(
            .WIDTH (WIDTH),
            .SHIFT (g),
            .ATAN  (atan_lut_entry(g, WIDTH))
        ) u_stage (
            .clk  (clk),
            .i_en (w_adv),
            .i_x  (w_x[g]),
            .i_y  (w_y[g]),
            .i_z  (w_z[g]),
            .o_x  (w_x[g+1]),
            .o_y  (w_y[g+1]),
            .o_z  (w_z[g+1])
        );
    end

    // Gain compensation and saturation into the output register.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_i <= scale_sat(w_x[DEPTH]);
            r_q <= scale_sat(w_y[DEPTH]);
        end
    end

`ifndef SYNTHESIS
    localparam logic signed [c_xw-1:0] c_wide_min = {1'b1, {(c_xw-1){1'b0}}};

    logic                 r_chk_hold;
    logic [2*WIDTH-1:0]   r_chk_data;

    // Stalled output must keep valid and data; wide datapath must never wrap.
    always_ff @(posedge clk) begin
        r_chk_hold <= !reset && m_valid && !m_ready;
        r_chk_data <= m_data;
        if (!reset) begin
            if (r_chk_hold) begin
                assert (m_valid && (m_data == r_chk_data));
            end
            for (int k = 0; k <= DEPTH; k++) begin
                if (r_valid[k]) begin
                    assert (w_x[k] != c_wide_min && w_y[k] != c_wide_min);
                    assert (w_z[k] <= c_pi_2 && w_z[k] >= -c_pi_2);
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_polar_to_cartesian.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_polar_to_cartesian
// Description : Self-checking bench for polar_to_cartesian (WIDTH=16,
//               DEPTH=14): directed vector table, random stream with
//               back-pressure against a trigonometric model, reset flush.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_polar_to_cartesian;

    localparam int W = 16;
    localparam int D = 14;
    localparam real PI = 3.14159265358979323846;

    logic           clk = 1'b0;
    logic           reset;
    logic           s_valid;
    logic           s_ready;
    logic [2*W-1:0] s_data;
    logic           m_valid;
    logic           m_ready;
    logic [2*W-1:0] m_data;

    always #5 clk = ~clk;

    polar_to_cartesian #(.WIDTH(W), .DEPTH(D)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    typedef struct { int mag; int phase; int exp_i; int exp_q; int tol; } vec_t;
    typedef struct { int exp_i; int exp_q; int tol; } exp_t;

    exp_t           exp_fifo[$];
    int             errors = 0;
    int             checks = 0;
    int             n_out  = 0;
    bit             accepted;
    bit             held = 1'b0;
    logic [2*W-1:0] held_data;

    task automatic check(input string name, input int act, input int req, input int tol);
        checks++;
        if (act > req + tol || act < req - tol) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (+/-%0d)", name, act, req, tol);
        end
    endtask

    function automatic int to_lsb(input real v);
        real r;
        int  n;
        r = (v >= 0.0) ? v + 0.5 : v - 0.5;
        n = $rtoi(r);
        if (n > 32767)  n = 32767;
        if (n < -32768) n = -32768;
        return n;
    endfunction

    // Reference: I = mag*cos(phase), Q = mag*sin(phase), phase scaled so 2^15 == pi.
    function automatic exp_t model(input int mag, input int ph);
        exp_t e;
        real  ang;
        ang     = real'(int'($signed(16'(ph)))) * PI / 32768.0;
        e.exp_i = to_lsb(real'(mag) * $cos(ang));
        e.exp_q = to_lsb(real'(mag) * $sin(ang));
        e.tol   = 9;
        return e;
    endfunction

    // One cycle, entered and left on a negedge: checks a pending stall, drives
    // inputs, scores any output being drained, records an accepted beat.
    task automatic drive(input bit sv, input int mag, input int ph, input bit mr, input exp_t e);
        exp_t x;
        if (held) begin
            check("hold_m_valid", int'(m_valid), 1, 0);
            check("hold_i", int'($signed(m_data[W-1:0])), int'($signed(held_data[W-1:0])), 0);
            check("hold_q", int'($signed(m_data[2*W-1:W])), int'($signed(held_data[2*W-1:W])), 0);
        end
        s_valid = sv;
        s_data  = {16'(mag), 16'(ph)};
        m_ready = mr;
        #1;
        if (m_valid && m_ready) begin
            if (exp_fifo.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_output: got m_data=%h, required no beat", m_data);
            end else begin
                x = exp_fifo.pop_front();
                check($sformatf("beat%0d_i", n_out), int'($signed(m_data[W-1:0])), x.exp_i, x.tol);
                check($sformatf("beat%0d_q", n_out), int'($signed(m_data[2*W-1:W])), x.exp_q, x.tol);
            end
            n_out++;
        end
        accepted = s_valid && s_ready;
        if (accepted) exp_fifo.push_back(e);
        held      = m_valid && !m_ready;
        held_data = m_data;
        @(negedge clk);
    endtask

    task automatic drain();
        exp_t z;
        z = '{0, 0, 0};
        for (int k = 0; k < 60 && exp_fifo.size() != 0; k++) drive(1'b0, 0, 0, 1'b1, z);
        check("drain_empty", exp_fifo.size(), 0, 0);
    endtask

    vec_t tbl [10];

    initial begin
        real  rt_ang;
        int   rt_phase, rt_mag, mag, ph, sent, guard, lat;
        exp_t z;

        z        = '{0, 0, 0};
        rt_ang   = $atan2(-7000.0, 10000.0);
        rt_phase = $rtoi(rt_ang * 32768.0 / PI - 0.5);
        rt_mag   = $rtoi($sqrt(1.0e8 + 4.9e7) * 1.6467602 / 2.0 + 0.5);

        tbl[0] = '{16384,      0,  16384,      0,  9};
        tbl[1] = '{16384,  16384,      0,  16384,  9};
        tbl[2] = '{16384, -32768, -16384,      0,  9};
        tbl[3] = '{16384, -16384,      0, -16384,  9};
        tbl[4] = '{16384,   8192,  11585,  11585,  9};
        tbl[5] = '{16384,  -8192,  11585, -11585,  9};
        tbl[6] = '{32767,      0,  32767,      0,  9};
        tbl[7] = '{-16384,     0, -16384,      0,  9};
        tbl[8] = '{-16384, 16384,      0, -16384,  9};
        tbl[9] = '{rt_mag, rt_phase, 8234, -5764, 12};

        // Reset state.
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_m_valid", int'(m_valid), 0, 0);
        reset   = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        check("post_reset_s_ready", int'(s_ready), 1, 0);
        check("post_reset_m_valid", int'(m_valid), 0, 0);

        // Directed vectors, streamed back to back.
        for (int k = 0; k < 10; k++)
            drive(1'b1, tbl[k].mag, tbl[k].phase, 1'b1, '{tbl[k].exp_i, tbl[k].exp_q, tbl[k].tol});
        drain();

        // Random stream with pseudo-random back-pressure.
        sent  = 0;
        guard = 0;
        mag   = int'($urandom_range(0, 24000)) - 12000;
        ph    = int'($urandom_range(0, 65535));
        while (sent < 64 && guard < 2000) begin
            drive(1'b1, mag, ph, $urandom_range(0, 1) == 1, model(mag, ph));
            guard++;
            if (accepted) begin
                sent++;
                mag = int'($urandom_range(0, 24000)) - 12000;
                ph  = int'($urandom_range(0, 65535));
            end
        end
        check("random_sent", sent, 64, 0);
        drain();

        // Reset with the pipeline full: nothing from before the reset may emerge.
        for (int k = 0; k < D + 2; k++) begin
            mag = int'($urandom_range(0, 24000)) - 12000;
            ph  = int'($urandom_range(0, 65535));
            drive(1'b1, mag, ph, 1'b1, model(mag, ph));
        end
        s_valid = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        check("flush_m_valid", int'(m_valid), 0, 0);
        reset = 1'b0;
        exp_fifo.delete();
        held = 1'b0;
        drive(1'b1, 16384, 16384, 1'b1, '{0, 16384, 9});
        s_valid = 1'b0;
        check("flush_accept", int'(accepted), 1, 0);
        lat = 1;
        while (!m_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("flush_latency", lat, D + 2, 0);
        drive(1'b0, 0, 0, 1'b1, z);
        check("flush_one_out", int'(m_valid), 0, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
